// File: rtl/match_scene_descriptor_param.sv
// match_scene_descriptor_param
// Buffers one scene descriptor, streams database descriptors against it and
// keeps the best and second-best sum-of-squared-byte distances. After the
// final database descriptor a single ratio-test result is strobed out.
// Optional build macro: MSD_DIST_THRESHOLD_EN adds iMaxDist, an absolute
// ceiling on the best distance for a match.
module match_scene_descriptor_param #(
  parameter int DESC_WORDS  = 64,
  parameter int WORD_W      = 16,
  parameter int DIST_W      = 23,
  parameter int IDX_W       = 12,
  parameter int RATIO_SHIFT = 1
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic [WORD_W-1:0] iDesc,
  input  logic              iSceneStart,
  input  logic              iDbStart,
  input  logic              iDbLast,
`ifdef MSD_DIST_THRESHOLD_EN
  input  logic [DIST_W-1:0] iMaxDist,
`endif
  output logic              oMatch,
  output logic [IDX_W-1:0]  oMatchIndex,
  output logic [DIST_W-1:0] oDist1,
  output logic [DIST_W-1:0] oDist2,
  output logic              oMatch_Valid
);

  localparam int BPW   = WORD_W / 8;
  localparam int CNT_W = $clog2(DESC_WORDS);
  localparam int CMP_W = DIST_W + RATIO_SHIFT;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DESC_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    DB_WAIT = 3'd2,
    ACCUM   = 3'd3,
    RESULT  = 3'd4
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DIST_W-1:0]   r_acc;
  logic [DIST_W-1:0]   r_best1;
  logic [DIST_W-1:0]   r_best2;
  logic [IDX_W-1:0]    r_best_idx;
  logic [IDX_W-1:0]    r_db_idx;
  logic                r_last;
  logic                r_match_ratio;
  logic [WORD_W-1:0]   r_buf [DESC_WORDS];

  logic                w_fire;
  logic                w_buf_we;
  logic [CNT_W-1:0]    w_buf_addr;
  logic [WORD_W-1:0]   w_ref_word;
  logic [15:0]         w_sq_byte [BPW];
  logic [DIST_W-1:0]   w_sq;
  logic [DIST_W-1:0]   w_acc_sum;
  logic [DIST_W-1:0]   w_nb1;
  logic [DIST_W-1:0]   w_nb2;
  logic [IDX_W-1:0]    w_nidx;
  logic [CMP_W-1:0]    w_lhs;
  logic [CMP_W-1:0]    w_rhs;
  logic                w_ratio_ok;

  assign oReady = (r_state != RESULT);
  assign w_fire = iValid & oReady;

  // A word with iDbStart always compares against scene word 0; otherwise
  // the word counter selects the scene word (it sits at 0 in DB_WAIT).
  assign w_ref_word = (r_state == ACCUM && !iDbStart) ? r_buf[r_cnt] : r_buf[0];

  // Per-byte squared absolute difference
  genvar gi;
  generate
    for (gi = 0; gi < BPW; gi++) begin : g_byte
      logic [7:0] w_a;
      logic [7:0] w_b;
      logic [7:0] w_diff;
      assign w_a    = iDesc[8*gi +: 8];
      assign w_b    = w_ref_word[8*gi +: 8];
      assign w_diff = (w_a > w_b) ? (w_a - w_b) : (w_b - w_a);
      assign w_sq_byte[gi] = {8'd0, w_diff} * {8'd0, w_diff};
    end
  endgenerate

  // Sum of the byte squares for the current word
  always_comb begin
    w_sq = '0;
    for (int k = 0; k < BPW; k++) begin
      w_sq = w_sq + DIST_W'(w_sq_byte[k]);
    end
  end

  assign w_acc_sum = r_acc + w_sq;

  // Candidate best/second-best if the current word completes a descriptor;
  // ties with best1 fall through to the second-best comparison
  always_comb begin
    w_nb1  = r_best1;
    w_nb2  = r_best2;
    w_nidx = r_best_idx;
    if (w_acc_sum < r_best1) begin
      w_nb2  = r_best1;
      w_nb1  = w_acc_sum;
      w_nidx = r_db_idx;
    end else if (w_acc_sum < r_best2) begin
      w_nb2  = w_acc_sum;
    end
  end

  // Ratio test widened so the shift never drops bits
  assign w_lhs      = CMP_W'(w_nb1) << RATIO_SHIFT;
  assign w_rhs      = CMP_W'(w_nb2);
  assign w_ratio_ok = (w_lhs < w_rhs);

  // Scene buffer write: word 0 on a scene start, then by word counter
  always_comb begin
    w_buf_we   = 1'b0;
    w_buf_addr = '0;
    if (w_fire) begin
      case (r_state)
        IDLE:    w_buf_we = iSceneStart;
        DB_WAIT: w_buf_we = iSceneStart & ~iDbStart;
        LOAD: begin
          w_buf_we   = 1'b1;
          w_buf_addr = r_cnt;
        end
        default: w_buf_we = 1'b0;
      endcase
    end
  end

  // Scene buffer storage (contents are don't-care until a full load)
  always_ff @(posedge iClk) begin
    if (w_buf_we) r_buf[w_buf_addr] <= iDesc;
  end

  // Control FSM, distance accumulation, best tracking and result registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_best1       <= '1;
      r_best2       <= '1;
      r_best_idx    <= '0;
      r_db_idx      <= '0;
      r_last        <= 1'b0;
      r_match_ratio <= 1'b0;
      oMatchIndex   <= '0;
      oDist1        <= '0;
      oDist2        <= '0;
      oMatch_Valid  <= 1'b0;
    end else begin
      oMatch_Valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fire && iSceneStart) begin
            r_cnt   <= CNT_W'(1);
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (w_fire) begin
            if (r_cnt == LAST_CNT) begin
              r_cnt      <= '0;
              r_best1    <= '1;
              r_best2    <= '1;
              r_best_idx <= '0;
              r_db_idx   <= '0;
              r_state    <= DB_WAIT;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        DB_WAIT: begin
          if (w_fire) begin
            if (iDbStart) begin
              r_acc   <= w_sq;
              r_cnt   <= CNT_W'(1);
              r_last  <= iDbLast;
              r_state <= ACCUM;
            end else if (iSceneStart) begin
              // Abandon this database pass; the new scene word 0 is written
              r_cnt   <= CNT_W'(1);
              r_state <= LOAD;
            end
          end
        end
        ACCUM: begin
          if (w_fire) begin
            if (iDbStart) begin
              // Restart the descriptor; the index is not advanced
              r_acc  <= w_sq;
              r_cnt  <= CNT_W'(1);
              r_last <= iDbLast;
            end else if (r_cnt == LAST_CNT) begin
              r_best1    <= w_nb1;
              r_best2    <= w_nb2;
              r_best_idx <= w_nidx;
              r_db_idx   <= r_db_idx + IDX_W'(1);
              r_cnt      <= '0;
              r_acc      <= '0;
              if (r_last) begin
                oDist1        <= w_nb1;
                oDist2        <= w_nb2;
                oMatchIndex   <= w_nidx;
                r_match_ratio <= w_ratio_ok;
                oMatch_Valid  <= 1'b1;
                r_state       <= RESULT;
              end else begin
                r_state <= DB_WAIT;
              end
            end else begin
              r_acc <= w_acc_sum;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        RESULT:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MSD_DIST_THRESHOLD_EN
  logic r_match_hold;
  logic w_match_now;

  // The distance ceiling is applied with iMaxDist as seen in the RESULT cycle
  assign w_match_now = r_match_ratio & (oDist1 <= iMaxDist);
  assign oMatch      = (r_state == RESULT) ? w_match_now : r_match_hold;

  // Hold the thresholded match until the next result
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_match_hold <= 1'b0;
    end else if (r_state == RESULT) begin
      r_match_hold <= w_match_now;
    end
  end
`else
  assign oMatch = r_match_ratio;
`endif

endmodule

// File: tb/tb_match_scene_descriptor_param.sv
// Directed testbench for match_scene_descriptor_param (default parameters).
// Build with MSD_DIST_THRESHOLD_EN defined to exercise the distance ceiling.
module tb_match_scene_descriptor_param;

  localparam int DESC_WORDS = 64;
  localparam int WORD_W     = 16;
  localparam int DIST_W     = 23;
  localparam int IDX_W      = 12;
  localparam logic [63:0] ALL_ONES = 64'h7F_FFFF;

  logic              iClk;
  logic              iRst_n;
  logic              iValid;
  logic              oReady;
  logic [WORD_W-1:0] iDesc;
  logic              iSceneStart;
  logic              iDbStart;
  logic              iDbLast;
`ifdef MSD_DIST_THRESHOLD_EN
  logic [DIST_W-1:0] iMaxDist;
`endif
  logic              oMatch;
  logic [IDX_W-1:0]  oMatchIndex;
  logic [DIST_W-1:0] oDist1;
  logic [DIST_W-1:0] oDist2;
  logic              oMatch_Valid;

  int n_checks  = 0;
  int n_errors  = 0;
  int valid_cnt = 0;
  int ready_bad = 0;
  bit use_gaps  = 0;

  match_scene_descriptor_param dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iValid      (iValid),
    .oReady      (oReady),
    .iDesc       (iDesc),
    .iSceneStart (iSceneStart),
    .iDbStart    (iDbStart),
    .iDbLast     (iDbLast),
`ifdef MSD_DIST_THRESHOLD_EN
    .iMaxDist    (iMaxDist),
`endif
    .oMatch      (oMatch),
    .oMatchIndex (oMatchIndex),
    .oDist1      (oDist1),
    .oDist2      (oDist2),
    .oMatch_Valid(oMatch_Valid)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Count result strobes and any ready drop outside a result cycle
  always @(negedge iClk) begin
    if (iRst_n && oMatch_Valid) valid_cnt++;
    if (iRst_n && !oReady && !oMatch_Valid) ready_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [7:0] v, input bit s, input bit d, input bit l);
    if (use_gaps && $urandom_range(0, 1) == 1) begin
      iValid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge iClk);
      #1;
    end
    iValid      = 1'b1;
    iDesc       = {v, v};
    iSceneStart = s;
    iDbStart    = d;
    iDbLast     = l;
    @(posedge iClk);
    #1;
    iValid      = 1'b0;
    iSceneStart = 1'b0;
    iDbStart    = 1'b0;
    iDbLast     = 1'b0;
  endtask

  task automatic send_desc(input logic [7:0] v, input bit scene, input bit db,
                           input bit last, input int n);
    for (int i = 0; i < n; i++) send_word(v, scene && i == 0, db && i == 0, last && i == 0);
  endtask

  // Called one step after the edge that accepted the final word
  task automatic expect_result(input string tag, input bit m, input int idx,
                               input logic [63:0] d1, input logic [63:0] d2);
    $display("result %s: valid=%0b match=%0b idx=%0d d1=%0d d2=%0d",
             tag, oMatch_Valid, oMatch, oMatchIndex, oDist1, oDist2);
    chk({tag, "_valid"}, oMatch_Valid, 1);
    chk({tag, "_ready_low"}, oReady, 0);
    chk({tag, "_match"}, oMatch, m);
    chk({tag, "_idx"}, oMatchIndex, idx);
    chk({tag, "_dist1"}, oDist1, d1);
    chk({tag, "_dist2"}, oDist2, d2);
    @(posedge iClk);
    #1;
    chk({tag, "_valid_drop"}, oMatch_Valid, 0);
    chk({tag, "_ready_back"}, oReady, 1);
    chk({tag, "_dist1_hold"}, oDist1, d1);
  endtask

  task automatic run_case1();
    send_desc(8'h00, 1, 0, 0, DESC_WORDS);
    send_desc(8'h01, 0, 1, 0, DESC_WORDS);
    send_desc(8'h03, 0, 1, 1, DESC_WORDS);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, oReady, 1);
    chk({tag, "_valid"}, oMatch_Valid, 0);
    chk({tag, "_match"}, oMatch, 0);
    chk({tag, "_idx"}, oMatchIndex, 0);
    chk({tag, "_dist1"}, oDist1, 0);
    chk({tag, "_dist2"}, oDist2, 0);
  endtask

  int v0;

  initial begin
    iRst_n = 1'b0; iValid = 1'b0; iDesc = '0;
    iSceneStart = 1'b0; iDbStart = 1'b0; iDbLast = 1'b0;
`ifdef MSD_DIST_THRESHOLD_EN
    iMaxDist = '1;
`endif
    repeat (3) @(posedge iClk);
    #1;
    check_reset_vals("reset");
    iRst_n = 1'b1;
    @(posedge iClk);
    #1;

    // Two descriptors, clear winner: 128*1 and 128*9
    run_case1();
    expect_result("case1", 1, 0, 128, 1152);

    // Exact tie: first keeps best1, second becomes best2
    send_desc(8'h00, 1, 0, 0, DESC_WORDS);
    send_desc(8'h02, 0, 1, 0, DESC_WORDS);
    send_desc(8'h02, 0, 1, 1, DESC_WORDS);
    expect_result("tie", 0, 0, 512, 512);

    // Random stalls must not change the result
    ready_bad = 0;
    use_gaps  = 1;
    run_case1();
    use_gaps  = 0;
    expect_result("gaps", 1, 0, 128, 1152);
    chk("ready_only_in_result", ready_bad, 0);

    // Descriptor restarted at word 10; only one descriptor counted
    send_desc(8'h00, 1, 0, 0, DESC_WORDS);
    send_desc(8'h01, 0, 1, 0, 10);
    send_desc(8'h01, 0, 1, 1, DESC_WORDS);
    expect_result("restart", 1, 0, 128, ALL_ONES);

    // Scene abort in DB_WAIT, then a fresh scene (bytes 0x05) and db set
    v0 = valid_cnt;
    send_desc(8'h00, 1, 0, 0, DESC_WORDS);
    send_desc(8'h01, 0, 1, 0, DESC_WORDS);
    send_desc(8'h05, 1, 0, 0, DESC_WORDS);
    send_desc(8'h04, 0, 1, 0, DESC_WORDS);
    send_desc(8'h05, 0, 1, 1, DESC_WORDS);
    expect_result("abort", 1, 1, 0, 128);
    chk("abort_one_strobe", valid_cnt - v0, 1);

`ifdef MSD_DIST_THRESHOLD_EN
    iMaxDist = 23'd100;
    run_case1();
    expect_result("thr100", 0, 0, 128, 1152);
    iMaxDist = 23'd128;
    run_case1();
    expect_result("thr128", 1, 0, 128, 1152);
    iMaxDist = '1;
`endif

    // Asynchronous reset in the middle of a database descriptor
    send_desc(8'h00, 1, 0, 0, DESC_WORDS);
    send_desc(8'h01, 0, 1, 0, 20);
    #2;
    iRst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    @(posedge iClk);
    #1;
    run_case1();
    expect_result("after_reset", 1, 0, 128, 1152);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
